// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: RV32/64 M-extension multiply/divide unit for the execute stage.
// Optional single-cycle multiplier when EX_MD_FAST_MUL_EN is defined.
module ex_muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            md_req_valid,
   output logic            md_req_ready,
   input  logic [2:0]      md_op,
   input  logic [XLEN-1:0] md_oprand1,
   input  logic [XLEN-1:0] md_oprand2,
   input  logic [4:0]      md_wr_regindex,
   input  logic            md_flush,
   output logic            md_resp_valid,
   input  logic            md_resp_ready,
   output logic [XLEN-1:0] md_resp_wdata,
   output logic [4:0]      md_resp_regindex,
   output logic            md_busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      op_q, op_d;
   logic            neg_q, neg_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] b_q, b_d;
   logic            valid_q, valid_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [4:0]      idx_q, idx_d;

   logic            s1_sgn, s2_sgn, neg1, neg2;
   logic [XLEN-1:0] mag1, mag2;
   logic            is_div, dz, ovf;
   logic [XLEN:0]   msum, dsh, ddiff;
   logic [XLEN-1:0] st_hi, st_lo;

   // Final sign fix-up and result select from the raw magnitude result.
   function automatic logic [XLEN-1:0] fin(
      input logic [2:0]      op,
      input logic            neg,
      input logic [XLEN-1:0] hi,
      input logic [XLEN-1:0] lo
   );
      logic [2*XLEN-1:0] p;
      logic [XLEN-1:0]   q, r;
      p = neg ? -{hi, lo} : {hi, lo};
      q = neg ? -lo : lo;
      r = neg ? -hi : hi;
      if (op[2])
         fin = op[1] ? r : q;
      else if (op == 3'd0)
         fin = p[XLEN-1:0];
      else
         fin = p[2*XLEN-1:XLEN];
   endfunction

   // Operand signedness, magnitudes and special-case detection.
   always_comb begin
      s1_sgn = ~((md_op == 3'd3) | (md_op == 3'd5) | (md_op == 3'd7));
      s2_sgn = s1_sgn & (md_op != 3'd2);
      neg1   = s1_sgn & md_oprand1[XLEN-1];
      neg2   = s2_sgn & md_oprand2[XLEN-1];
      mag1   = neg1 ? -md_oprand1 : md_oprand1;
      mag2   = neg2 ? -md_oprand2 : md_oprand2;
      is_div = md_op[2];
      dz     = is_div & (md_oprand2 == '0);
      ovf    = is_div & ~md_op[0] & (md_oprand1 == MINV)
               & (&md_oprand2);
   end

`ifdef EX_MD_FAST_MUL_EN
   logic [2*XLEN-1:0] fprod;
   assign fprod = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
`endif

   // One shift-add or restoring subtract-shift step.
   always_comb begin
      msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      dsh   = {hi_q, lo_q[XLEN-1]};
      ddiff = dsh - {1'b0, b_q};
      if (op_q[2]) begin
         if (!ddiff[XLEN]) begin
            st_hi = ddiff[XLEN-1:0];
            st_lo = {lo_q[XLEN-2:0], 1'b1};
         end else begin
            st_hi = dsh[XLEN-1:0];
            st_lo = {lo_q[XLEN-2:0], 1'b0};
         end
      end else begin
         st_hi = msum[XLEN:1];
         st_lo = {msum[0], lo_q[XLEN-1:1]};
      end
   end

   // Next-state: flush beats request and response handshakes.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      neg_d   = neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      b_d     = b_q;
      valid_d = valid_q;
      wdata_d = wdata_q;
      idx_d   = idx_q;
      if (md_flush) begin
         state_d = IDLE;
         valid_d = 1'b0;
         wdata_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (md_req_valid) begin
                  op_d  = md_op;
                  idx_d = md_wr_regindex;
                  cnt_d = '0;
                  hi_d  = '0;
                  lo_d  = is_div ? mag1 : mag2;
                  b_d   = is_div ? mag2 : mag1;
                  neg_d = (md_op[2] & md_op[1]) ? neg1 : (neg1 ^ neg2);
                  if (dz) begin
                     state_d = DONE;
                     valid_d = 1'b1;
                     wdata_d = md_op[1] ? md_oprand1 : '1;
                  end else if (ovf) begin
                     state_d = DONE;
                     valid_d = 1'b1;
                     wdata_d = md_op[1] ? '0 : MINV;
`ifdef EX_MD_FAST_MUL_EN
                  end else if (!is_div) begin
                     state_d = DONE;
                     valid_d = 1'b1;
                     wdata_d = fin(md_op, neg1 ^ neg2,
                                   fprod[2*XLEN-1:XLEN],
                                   fprod[XLEN-1:0]);
`endif
                  end else begin
                     state_d = CALC;
                  end
               end
            end
            CALC: begin
               hi_d  = st_hi;
               lo_d  = st_lo;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  state_d = DONE;
                  valid_d = 1'b1;
                  wdata_d = fin(op_q, neg_q, st_hi, st_lo);
               end
            end
            DONE: begin
               if (md_resp_ready) begin
                  state_d = IDLE;
                  valid_d = 1'b0;
                  wdata_d = '0;
               end
            end
            default: begin
               state_d = IDLE;
               valid_d = 1'b0;
               wdata_d = '0;
            end
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         neg_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         b_q     <= '0;
         valid_q <= 1'b0;
         wdata_q <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         b_q     <= b_d;
         valid_q <= valid_d;
         wdata_q <= wdata_d;
         idx_q   <= idx_d;
      end
   end

   assign md_req_ready     = (state_q == IDLE) & ~md_flush;
   assign md_busy          = (state_q != IDLE);
   assign md_resp_valid    = valid_q;
   assign md_resp_wdata    = wdata_q;
   assign md_resp_regindex = idx_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed vector bench for ex_muldiv_unit (XLEN=32).
// Expected latencies follow EX_MD_FAST_MUL_EN when defined.
module tb_ex_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        md_req_valid;
   logic        md_req_ready;
   logic [2:0]  md_op;
   logic [31:0] md_oprand1;
   logic [31:0] md_oprand2;
   logic [4:0]  md_wr_regindex;
   logic        md_flush;
   logic        md_resp_valid;
   logic        md_resp_ready;
   logic [31:0] md_resp_wdata;
   logic [4:0]  md_resp_regindex;
   logic        md_busy;

   int n_chk = 0;
   int n_fail = 0;

`ifdef EX_MD_FAST_MUL_EN
   localparam int ML = 1;
`else
   localparam int ML = 33;
`endif

   ex_muldiv_unit #(.XLEN(32)) dut (
      .clk              (clk),
      .reset            (reset),
      .md_req_valid     (md_req_valid),
      .md_req_ready     (md_req_ready),
      .md_op            (md_op),
      .md_oprand1       (md_oprand1),
      .md_oprand2       (md_oprand2),
      .md_wr_regindex   (md_wr_regindex),
      .md_flush         (md_flush),
      .md_resp_valid    (md_resp_valid),
      .md_resp_ready    (md_resp_ready),
      .md_resp_wdata    (md_resp_wdata),
      .md_resp_regindex (md_resp_regindex),
      .md_busy          (md_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  idx;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vt[20];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Drive one request; returns #1 after the accepting edge.
   task automatic issue(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] idx);
      @(negedge clk);
      md_req_valid   = 1'b1;
      md_op          = op;
      md_oprand1     = a;
      md_oprand2     = b;
      md_wr_regindex = idx;
      @(posedge clk);
      #1;
      md_req_valid   = 1'b0;
      md_op          = ~op;
      md_oprand1     = 32'hFFFF_FFFF;
      md_oprand2     = 32'hFFFF_FFFF;
      md_wr_regindex = ~idx;
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] idx,
                         output int lat, output logic [31:0] d,
                         output logic [4:0] ri, output logic zok);
      issue(op, a, b, idx);
      lat = 0;
      zok = 1'b1;
      do begin
         @(negedge clk);
         lat++;
         if (!md_resp_valid && md_resp_wdata != 0) zok = 1'b0;
      end while (!md_resp_valid && lat < 100);
      d  = md_resp_wdata;
      ri = md_resp_regindex;
   endtask

   initial begin
      int          lat;
      int          seen;
      logic [31:0] d;
      logic [4:0]  ri;
      logic        zok;

      vt[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, ML};
      vt[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, ML};
      vt[2]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3,  32'hFFFF_FFFF, ML};
      vt[3]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, ML};
      vt[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  32'hFFFF_FFFD, 33};
      vt[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  32'hFFFF_FFFF, 33};
      vt[6]  = '{3'd5, 32'h0000_0009, 32'h0000_0000, 5'd7,  32'hFFFF_FFFF, 1};
      vt[7]  = '{3'd7, 32'h0000_0005, 32'h0000_0000, 5'd8,  32'h0000_0005, 1};
      vt[8]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h8000_0000, 1};
      vt[9]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0000_0000, 1};
      vt[10] = '{3'd5, 32'd100,       32'd7,         5'd11, 32'd14,        33};
      vt[11] = '{3'd7, 32'd100,       32'd7,         5'd12, 32'd2,         33};
      vt[12] = '{3'd1, 32'hFFFF_FFFD, 32'h0000_0005, 5'd13, 32'hFFFF_FFFF, ML};
      vt[13] = '{3'd3, 32'h1234_5678, 32'h0000_0010, 5'd14, 32'h0000_0001, ML};
      vt[14] = '{3'd4, 32'd100,       32'hFFFF_FFF9, 5'd15, 32'hFFFF_FFF2, 33};
      vt[15] = '{3'd6, 32'd100,       32'hFFFF_FFF9, 5'd16, 32'h0000_0002, 33};
      vt[16] = '{3'd6, 32'hFFFF_FF9C, 32'd7,         5'd17, 32'hFFFF_FFFE, 33};
      vt[17] = '{3'd0, 32'h0001_0000, 32'h0001_0000, 5'd18, 32'h0000_0000, ML};
      vt[18] = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 5'd19, 32'hFFFF_FFF9, 1};
      vt[19] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd31, 32'h0000_0000, 33};

      reset          = 1'b1;
      md_req_valid   = 1'b0;
      md_op          = '0;
      md_oprand1     = '0;
      md_oprand2     = '0;
      md_wr_regindex = '0;
      md_flush       = 1'b0;
      md_resp_ready  = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst_valid", {63'd0, md_resp_valid}, 64'd0);
      chk("rst_wdata", {32'd0, md_resp_wdata}, 64'd0);
      chk("rst_idx",   {59'd0, md_resp_regindex}, 64'd0);
      chk("rst_busy",  {63'd0, md_busy}, 64'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ready", {63'd0, md_req_ready}, 64'd1);

      for (int i = 0; i < 20; i++) begin
         run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].idx, lat, d, ri, zok);
         chk($sformatf("v%0d_data", i), {32'd0, d}, {32'd0, vt[i].exp});
         chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vt[i].lat));
         chk($sformatf("v%0d_idx", i), {59'd0, ri}, {59'd0, vt[i].idx});
         chk($sformatf("v%0d_wzero", i), {63'd0, zok}, 64'd1);
         @(negedge clk);
         chk($sformatf("v%0d_idle", i),
             {62'd0, md_busy, md_req_ready}, 64'd1);
      end

      md_resp_ready = 1'b0;
      run_op(3'd5, 32'd100, 32'd7, 5'd6, lat, d, ri, zok);
      chk("hold_lat", 64'(lat), 64'd33);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         chk($sformatf("hold%0d", k),
             {31'd0, md_resp_valid, md_resp_wdata}, {31'd0, 1'b1, 32'd14});
      end
      @(negedge clk);
      md_resp_ready = 1'b1;
      chk("hold4", {31'd0, md_resp_valid, md_resp_wdata},
          {31'd0, 1'b1, 32'd14});
      @(negedge clk);
      chk("hold_exit", {29'd0, md_resp_valid, md_busy, md_req_ready,
          md_resp_wdata}, {29'd0, 3'b001, 32'd0});

      issue(3'd4, 32'd1000, 32'd3, 5'd9);
      repeat (5) @(negedge clk);
      chk("calc_busy", {62'd0, md_busy, md_req_ready}, 64'd2);
      chk("calc_idx", {59'd0, md_resp_regindex}, 64'd9);
      repeat (5) @(negedge clk);
      md_flush = 1'b1;
      #1;
      chk("flush_cyc", {61'd0, md_busy, md_req_ready, md_resp_valid},
          64'd4);
      @(negedge clk);
      md_flush = 1'b0;
      #1;
      chk("flush_after", {61'd0, md_busy, md_req_ready, md_resp_valid},
          64'd2);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (md_resp_valid) seen++;
      end
      chk("flush_noresp", 64'(seen), 64'd0);

      issue(3'd4, 32'd1000, 32'd3, 5'd9);
      repeat (10) @(negedge clk);
      reset    = 1'b1;
      md_flush = 1'b1;
      @(negedge clk);
      reset    = 1'b0;
      md_flush = 1'b0;
      #1;
      chk("rst_mid", {24'd0, md_busy, md_req_ready, md_resp_valid,
          md_resp_regindex, md_resp_wdata},
          {24'd0, 3'b010, 5'd0, 32'd0});
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (md_resp_valid) seen++;
      end
      chk("rst_noresp", 64'(seen), 64'd0);

      md_resp_ready = 1'b0;
      issue(3'd5, 32'd9, 32'd0, 5'd3);
      @(negedge clk);
      chk("done_valid", {31'd0, md_resp_valid, md_resp_wdata},
          {31'd0, 1'b1, 32'hFFFF_FFFF});
      md_flush      = 1'b1;
      md_resp_ready = 1'b1;
      @(negedge clk);
      md_flush = 1'b0;
      #1;
      chk("done_flush", {30'd0, md_resp_valid, md_busy, md_resp_wdata},
          64'd0);

      @(negedge clk);
      md_flush     = 1'b1;
      md_req_valid = 1'b1;
      md_op        = 3'd5;
      md_oprand1   = 32'd9;
      md_oprand2   = 32'd0;
      #1;
      chk("flush_rdy", {63'd0, md_req_ready}, 64'd0);
      @(negedge clk);
      md_flush     = 1'b0;
      md_req_valid = 1'b0;
      #1;
      chk("flush_req", {62'd0, md_busy, md_resp_valid}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 8..64, power of two.
REQ-002 Clocking is one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 md_req_valid  in  1  execute stage presents an M-extension operation.
REQ-006 md_req_ready  out  1  unit accepts a request this cycle.
REQ-007 md_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 md_oprand1  in  XLEN  rs1 value (multiplicand/dividend).
REQ-009 md_oprand2  in  XLEN  rs2 value (multiplier/divisor).
REQ-010 md_wr_regindex  in  5  destination register index, carried to the response.
REQ-011 md_flush  in  1  pipeline kill; abandons any in-flight operation.
REQ-012 md_resp_valid  out  1  result available.
REQ-013 md_resp_ready  in  1  memory stage consumes the result.
REQ-014 md_resp_wdata  out  XLEN  result for the register file.
REQ-015 md_resp_regindex  out  5  captured destination index.
REQ-016 md_busy  out  1  high whenever the state is not IDLE; drives the decode stall.

Function
REQ-017 State machine: IDLE, CALC, DONE.
REQ-018 md_req_ready = (state==IDLE) & !md_flush; a request is accepted on a cycle with md_req_valid & md_req_ready.
REQ-019 On accept, the unit registers md_op, operand magnitudes, result-sign flags and md_wr_regindex; later input changes have no effect.
REQ-020 Signedness: MUL/MULH/DIV/REM signed x signed; MULHSU signed rs1 x unsigned rs2; MULHU/DIVU/REMU unsigned.
REQ-021 MUL returns product[XLEN-1:0]; MULH* return product[2*XLEN-1:XLEN] of the full 2*XLEN-bit product.
REQ-022 Iterative path: IDLE->CALC on accept; CALC performs one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle for exactly XLEN cycles, counted by a $clog2(XLEN)+1-bit counter; CALC->DONE after the last step.
REQ-023 Division result sign: quotient negative iff operand signs differ (signed ops); remainder takes the dividend sign.
REQ-024 Divide by zero: DIV/DIVU return all ones; REM/REMU return md_oprand1; IDLE->DONE directly, no CALC.
REQ-025 Signed overflow (DIV/REM, rs1 = -2^(XLEN-1), rs2 = -1): DIV returns -2^(XLEN-1), REM returns 0; IDLE->DONE directly.
REQ-026 Latency from accept cycle N: iterative ops md_resp_valid at N+XLEN+1; special cases (REQ-024/025) at N+1.
REQ-027 In DONE, md_resp_valid=1 and md_resp_wdata/md_resp_regindex are held stable until md_resp_ready; DONE->IDLE on the md_resp_ready cycle.
REQ-028 A new request is accepted no earlier than the cycle after DONE exits (no back-to-back overlap).
REQ-029 md_flush in any state: state->IDLE next cycle, md_resp_valid low next cycle, result discarded; flush has priority over md_req_valid and md_resp_ready in the same cycle.
REQ-030 md_resp_valid is a registered output; md_resp_wdata is 0 whenever md_resp_valid is 0.

Reset
REQ-031 reset forces state IDLE, counter 0, md_resp_valid 0, md_resp_wdata 0, md_resp_regindex 0, md_busy 0; md_req_ready is 1 in the first cycle after reset deasserts.
REQ-032 reset asserted mid-CALC or in DONE discards the operation with no response; reset has priority over md_flush.

Configuration
REQ-033 Macro EX_MD_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU use a single-cycle 2*XLEN multiplier, IDLE->DONE on accept, result at N+1.
REQ-034 EX_MD_FAST_MUL_EN undefined: multiplies use the iterative path of REQ-022 (result at N+XLEN+1); division is iterative in both builds.

Verification (XLEN=32, md_resp_ready=1 unless stated)
REQ-035 MUL 7 x 0xFFFFFFFD -> wdata 0xFFFFFFEB at N+33 (at N+1 with EX_MD_FAST_MUL_EN).
REQ-036 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF; MULH 0x80000000 x 0x80000000 -> 0x40000000.
REQ-037 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD at N+33; REM same operands -> 0xFFFFFFFF; regindex 5 echoed on md_resp_regindex.
REQ-038 DIVU 9 / 0 -> 0xFFFFFFFF at N+1; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at N+1; REM same -> 0.
REQ-039 DIVU 100 / 7 with md_resp_ready low 4 cycles -> md_resp_valid held 5 cycles with wdata 14 stable, then IDLE and md_req_ready 1.
REQ-040 Flush at cycle N+10 of a DIV -> md_busy 0 and md_req_ready 1 at N+11, no md_resp_valid; reset at N+10 gives the same result with all outputs at reset values.
